// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared constants and helpers for the 8-bit synchronous FIFO and
//             its read-side stream adapter.
//  Contents : DATA_W       - default word width
//             FIFO_DEPTH   - FIFO depth in words
//             RD_CNT_W     - width of the optional delivered-word counter
//             c_RD_LATENCY - FIFO registered read latency in cycles
//             calc_room    - free skid-buffer slots available for a new read
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int RD_CNT_W     = 16;
    localparam int c_RD_LATENCY = 1;

    // Slots left once the words already held or in flight are accounted for,
    // crediting the slot freed by a pop in the same cycle. Occupancy plus
    // in-flight never exceeds 2, so the result stays within 0..2.
    function automatic logic [1:0] calc_room(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] avail;
        avail = 3'd2 + {2'b00, pop} - {1'b0, occ} - {2'b00, inflight};
        return avail[1:0];
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
//  Module   : skid_buf2
//  Purpose  : Two-entry in-order skid buffer. A push lands in the head slot
//             when the buffer is empty after this cycle's pop, otherwise in
//             the tail slot; a pop shifts the tail into the head.
//  Ports    : clk         - rising-edge clock
//             rst         - synchronous active-low reset
//             i_push      - write i_push_data at this edge
//             i_push_data - word to store
//             i_pop       - head consumed at this edge (ignored when empty)
//             o_occ       - occupancy, 0..2
//             o_valid     - head holds a valid word (registered)
//             o_data      - head word
//  Revision : 1.0  initial release
// ============================================================================
module skid_buf2 #(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [1:0]        o_occ,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic [1:0]        r_occ;
    logic              r_valid;

    logic              w_pop;
    logic [1:0]        w_occ_after_pop;
    logic [1:0]        w_occ_next;

    always_comb begin
        w_pop           = i_pop && r_valid;
        w_occ_after_pop = r_occ - {1'b0, w_pop};
        w_occ_next      = w_occ_after_pop + {1'b0, i_push};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_occ   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            r_valid <= (w_occ_next != 2'd0);
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            // The push follows the shift so a simultaneous pop+push lands
            // behind whatever word is now at the head.
            if (i_push) begin
                if (w_occ_after_pop == 2'd0) begin
                    r_buf0 <= i_push_data;
                end else begin
                    r_buf1 <= i_push_data;
                end
            end
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = r_valid;
    assign o_data  = r_buf0;

endmodule : skid_buf2
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_stream
//  Purpose  : Drains the synchronous FIFO onto a valid/ready stream. Issues
//             FIFO reads only when a skid-buffer slot is guaranteed for the
//             returning word, absorbing the FIFO's one-cycle read latency and
//             sustaining one word per cycle under continuous m_ready.
//  Ports    : clk           - rising-edge clock shared with the FIFO
//             rst           - synchronous active-low reset
//             enable        - permits new FIFO reads (buffered words drain)
//             fifo_empty    - FIFO empty flag
//             fifo_data_out - FIFO read data, valid the cycle after fifo_re
//             fifo_re       - FIFO read enable (combinational)
//             m_data        - stream data (head of skid buffer)
//             m_valid       - stream valid
//             m_ready       - stream ready
//             rd_count      - delivered-word counter (FIFO_RD_CNT_EN only)
//  Options  : FIFO_RD_CNT_EN - adds rd_count port and counter
//  Revision : 1.0  initial release
// ============================================================================
module fifo_rd_stream #(
    parameter int DATA_W = fifo_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          fifo_empty,
    input  logic [DATA_W-1:0]             fifo_data_out,
    output logic                          fifo_re,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [fifo_pkg::RD_CNT_W-1:0] rd_count
`endif
);

    import fifo_pkg::*;

    // One stage per cycle of FIFO read latency: set the cycle after the
    // FIFO accepted a read, i.e. while its word is on fifo_data_out.
    logic [c_RD_LATENCY-1:0] r_inflight;

    logic       w_pop;
    logic [1:0] w_occ;
    logic [1:0] w_room;
    logic       w_re;

    always_comb begin
        w_pop  = m_valid && m_ready;
        w_room = calc_room(w_occ, r_inflight, w_pop);
        // m_ready reaches fifo_re combinationally through w_pop; that credit
        // is what allows back-to-back reads at full rate.
        w_re   = rst && enable && !fifo_empty && (w_room != 2'd0);
    end

    assign fifo_re = w_re;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= w_re;
        end
    end

    skid_buf2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (fifo_data_out),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_valid     (m_valid),
        .o_data      (m_data)
    );

`ifdef FIFO_RD_CNT_EN
    logic [RD_CNT_W-1:0] r_rd_count;

    // Free-running, wraps naturally at 2^RD_CNT_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_count <= '0;
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + RD_CNT_W'(1);
        end
    end

    assign rd_count = r_rd_count;
`endif

endmodule : fifo_rd_stream
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_stream
//  Purpose  : Self-checking bench for fifo_rd_stream. A queue-based FIFO
//             model feeds the DUT; a scoreboard checks that every word
//             written to the FIFO leaves the stream once, in order, and that
//             at most two words are ever read but not yet delivered.
//  Options  : FIFO_RD_CNT_EN - also checks rd_count
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_rd_stream;

    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data_out;
    logic       fifo_re;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
`ifdef FIFO_RD_CNT_EN
    logic [RD_CNT_W-1:0] rd_count;
`endif

    always #20 clk = ~clk;

    fifo_rd_stream #(.DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_re       (fifo_re),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count      (rd_count)
`endif
    );

    // ---------------- FIFO model ----------------
    logic [7:0] mem [4096];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       empty_ovr = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr) || empty_ovr;

    always @(posedge clk) begin
        if (!rst) begin
            rd_ptr        <= wr_ptr;
            fifo_data_out <= 8'h00;
        end else if (fifo_re && (wr_ptr != rd_ptr)) begin
            fifo_data_out <= mem[rd_ptr % 4096];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    // ---------------- bookkeeping ----------------
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         outstanding = 0;
    int         pops = 0;
    bit         have_prev = 0;
    logic [7:0] prev_data;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr % 4096] = d;
        wr_ptr++;
        exp_q.push_back(d);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            outstanding = 0;
            pops        = 0;
            have_prev   = 0;
        end else begin
            chk(dut.w_occ <= 2'd2, "occ_le2", dut.w_occ, 2);
            chk(!(fifo_re && fifo_empty), "re_while_empty", fifo_re, 0);
            chk(outstanding <= 2, "read_not_delivered_le2", outstanding, 2);
            if (have_prev)
                chk(m_valid && (m_data == prev_data), "stall_hold", {m_valid, m_data}, {1'b1, prev_data});
`ifdef FIFO_RD_CNT_EN
            chk(rd_count == pops[15:0], "rd_count", rd_count, pops[15:0]);
`endif
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "pop_unexpected", m_data, -1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk(m_data == e, "stream_data", m_data, e);
                end
                got_q.push_back(m_data);
                pops++;
                outstanding--;
            end
            if (fifo_re) outstanding++;
            have_prev = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        enable    = 1'b0;
        m_ready   = 1'b0;
        empty_ovr = 1'b0;
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        logic rst_v;
        logic en_v;
        logic empty_v;
        logic rdy_v;
        logic exp_re;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int re_n, v_n, first_re, last_re, first_v, last_v, hold_n, c;

        // fifo_re from the idle post-reset state: nothing buffered, so only
        // rst, enable and fifo_empty matter.
        for (int i = 0; i < 16; i++) begin
            tbl[i].rst_v   = i[3];
            tbl[i].en_v    = i[2];
            tbl[i].empty_v = i[1];
            tbl[i].rdy_v   = i[0];
            tbl[i].exp_re  = i[3] & i[2] & ~i[1];
        end

        rst = 1'b0; enable = 1'b0; m_ready = 1'b0;
        step();
        do_reset();

        // ---- reset state ----
        chk(m_valid == 1'b0, "reset_m_valid", m_valid, 0);
        chk(m_data == 8'h00, "reset_m_data", m_data, 0);
        chk(fifo_re == 1'b0, "reset_fifo_re", fifo_re, 0);

        // ---- table: combinational fifo_re (all within one clock phase) ----
        push_word(8'h5A);
        for (int i = 0; i < 16; i++) begin
            rst       = tbl[i].rst_v;
            enable    = tbl[i].en_v;
            empty_ovr = tbl[i].empty_v;
            m_ready   = tbl[i].rdy_v;
            #1;
            chk(fifo_re == tbl[i].exp_re, $sformatf("tbl_re[%0d]", i), fifo_re, tbl[i].exp_re);
        end
        rst = 1'b1; enable = 1'b0; empty_ovr = 1'b0; m_ready = 1'b0;
        do_reset();

        // ---- full-rate drain of 16 words ----
        for (int i = 1; i <= FIFO_DEPTH; i++) push_word(8'(i));
        enable = 1'b1; m_ready = 1'b1;
        got_q.delete();
        re_n = 0; v_n = 0; first_re = -1; last_re = -1; first_v = -1; last_v = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (fifo_re) begin
                if (first_re < 0) first_re = k;
                last_re = k; re_n++;
            end
            if (m_valid) begin
                if (first_v < 0) first_v = k;
                last_v = k; v_n++;
            end
        end
        chk(re_n == 16, "burst_re_count", re_n, 16);
        chk(last_re - first_re == 15, "burst_re_consecutive", last_re - first_re, 15);
        chk(first_v - first_re == 2, "first_word_latency", first_v - first_re, 2);
        chk(v_n == 16 && last_v - first_v == 15, "burst_valid_consecutive", v_n, 16);
        chk(got_q.size() == 16, "burst_delivered", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            chk(got_q[i] == 8'(i + 1), "burst_order", got_q[i], i + 1);
`ifdef FIFO_RD_CNT_EN
        chk(rd_count == 16'd16, "burst_rd_count", rd_count, 16);
`endif
        step();

        // ---- backpressure: hold 0xA5 for 10 cycles ----
        do_reset();
        push_word(8'hA5); push_word(8'h11); push_word(8'h22); push_word(8'h33);
        enable = 1'b1; m_ready = 1'b0;
        re_n = 0; hold_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (fifo_re) re_n++;
            if (m_valid && m_data == 8'hA5) hold_n++;
        end
        chk(re_n == 2, "stall_reads", re_n, 2);
        chk(hold_n == 10, "stall_hold_cycles", hold_n, 10);
        step();
        got_q.delete();
        m_ready = 1'b1;
        repeat (6) step();
        chk(got_q.size() >= 3, "stall_release_count", got_q.size(), 3);
        if (got_q.size() >= 3) begin
            chk(got_q[0] == 8'hA5, "stall_release_w0", got_q[0], 8'hA5);
            chk(got_q[1] == 8'h11, "stall_release_w1", got_q[1], 8'h11);
            chk(got_q[2] == 8'h22, "stall_release_w2", got_q[2], 8'h22);
        end

        // ---- empty FIFO ----
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        re_n = 0; v_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_re) re_n++;
            if (m_valid) v_n++;
        end
        chk(re_n == 0, "empty_no_re", re_n, 0);
        chk(v_n == 0, "empty_no_valid", v_n, 0);
        step();

        // ---- enable dropped after 3 reads ----
        do_reset();
        for (int i = 0; i < 8; i++) push_word(8'h40 + 8'(i));
        m_ready = 1'b1; enable = 1'b1;
        got_q.delete();
        re_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_re) re_n++;
            if (re_n == 3) break;
        end
        step();
        enable = 1'b0;
        repeat (10) step();
        chk(got_q.size() == 3, "enable_drop_delivered", got_q.size(), 3);
        chk(wr_ptr - rd_ptr == 5, "enable_drop_remaining", wr_ptr - rd_ptr, 5);

        // ---- m_ready toggling over 16 words ----
        do_reset();
        for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
        enable = 1'b1;
        got_q.delete();
        c = 0;
        while (c < 100 && got_q.size() < 16) begin
            m_ready = (c % 2 == 0);
            step();
            c++;
        end
        chk(got_q.size() == 16, "toggle_delivered", got_q.size(), 16);
        chk(exp_q.size() == 0, "toggle_no_drop", exp_q.size(), 0);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            chk(got_q[i] == 8'h80 + 8'(i), "toggle_order", got_q[i], 8'h80 + i);

        // ---- reset while the buffer is full ----
        do_reset();
        for (int i = 0; i < 6; i++) push_word(8'hC0 + 8'(i));
        enable = 1'b1; m_ready = 1'b1;
        repeat (3) step();
        m_ready = 1'b0;
        repeat (4) step();
        chk(outstanding == 2, "full_before_reset", outstanding, 2);
        rst = 1'b0;
        step();
        chk(m_valid == 1'b0, "midrst_m_valid", m_valid, 0);
        chk(m_data == 8'h00, "midrst_m_data", m_data, 0);
`ifdef FIFO_RD_CNT_EN
        chk(rd_count == '0, "midrst_rd_count", rd_count, 0);
`endif
        rst = 1'b1; enable = 1'b0;
        step();

        // ---- randomized traffic ----
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            enable  = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 1 && (wr_ptr - rd_ptr) < 32)
                push_word(8'($urandom));
            step();
        end
        enable = 1'b1; m_ready = 1'b1;
        c = 0;
        while (c < 200 && (exp_q.size() != 0 || m_valid)) begin
            step();
            c++;
        end
        chk(exp_q.size() == 0, "random_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fifo_rd_stream
`default_nettype wire

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain controller for the 8-bit synchronous FIFO. It issues read enables into the FIFO, absorbs the FIFO's one-cycle registered read latency, and presents words in order on a valid/ready stream for downstream consumers. A 2-entry skid buffer sustains one word per cycle while `m_ready` stays high, and never reads an empty FIFO.

## Interface
- `DATA_W`, 8, word width; matches the FIFO `data_out` width.
- `clk` in 1: rising-edge clock, shared with the FIFO.
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: permits new FIFO reads; buffered words still drain when low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data_out` in DATA_W: FIFO read data, valid the cycle after `fifo_re` was sampled.
- `fifo_re` out 1: FIFO read enable, combinational.
- `m_data` out DATA_W: head word of the skid buffer.
- `m_valid` out 1: `m_data` holds a valid word.
- `m_ready` in 1: downstream accepts the word when both `m_valid` and `m_ready` are high.
- `rd_count` out 16: words delivered; present only under `FIFO_RD_CNT_EN`.

## Operation
- State:
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 1 bit; set in the cycle after the FIFO samples `fifo_re`=1.
  - `buf0` (head) and `buf1`.
- `pop` = `m_valid && m_ready`.
- `room` = 2 − `occ` − `inflight` + `pop`, 0..2.
- `fifo_re` = `rst` && `enable` && !`fifo_empty` && (`room` ≥ 1).
  - `fifo_re` is never high while `fifo_empty` is high.
  - The combinational path from `m_ready` to `fifo_re` is intentional.
- Capture: when `inflight`=1, `fifo_data_out` is written at the next edge.
  - It goes into `buf0` if the buffer is empty after this cycle's `pop`; otherwise into `buf1`.
- Pop: `buf1` shifts into `buf0`.
- Pop and capture in the same cycle: the shift and the write are both applied, and order is preserved.
- `occ_next` = `occ` + `inflight` − `pop`.
  - Reaching 3 is impossible by construction.
  - The bench asserts `occ` ≤ 2.
- `m_valid` = (`occ` ≠ 0), registered. `m_data` = `buf0`.
- `m_data` and `m_valid` hold stable while `m_valid`=1 and `m_ready`=0.
- `enable` falling: no new `fifo_re`. Any in-flight word is still captured, and all buffered words are still delivered.
- `fifo_empty` rising mid-stream: reads stop, and buffered words continue to drain.
- `fifo_empty` falls again: reads resume with no loss or duplication.

## Timing
- Reset (`rst`=0 at an edge) sets `m_valid`=0, `m_data`=0, `occ`=0, `inflight`=0 and `rd_count`=0.
  - `fifo_re` is 0 while `rst`=0.
  - Buffered and in-flight words are discarded.
- Latency: `fifo_re` sampled at edge k → word in buffer at edge k+1 → `m_valid`=1 during cycle k+1. This is a first-word latency of 2 edges from an idle FIFO.
- Throughput: 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- Backpressure: with `m_ready` low, at most 2 more words are read after the stall begins, then `fifo_re` stays low until a pop occurs.
- Reset asserted mid-burst: the FIFO word popped by the last `fifo_re` is lost. This is accepted; the system resets the FIFO together with this block.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - `rd_count` increments by 1 on each `pop` and wraps from 65535 to 0.
  - It is cleared by reset.
- `FIFO_RD_CNT_EN` undefined:
  - The `rd_count` port and counter are absent.
  - All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`: `DATA_W` default (8), `FIFO_DEPTH` (16), `RD_CNT_W` (16), and the FIFO read-latency constant (1).
- One sub-module, `skid_buf2`: the 2-entry buffer with push/pop/occupancy.
- The top level holds the `inflight`, `room` and `fifo_re` logic and the optional counter.

## Test plan
- Reset, then FIFO loaded with 16 words 0x01..0x10, `enable`=1, `m_ready`=1:
  - `fifo_re` is high for 16 consecutive cycles.
  - 0x01..0x10 appear on consecutive cycles, the first 2 edges after the first `fifo_re`.
  - `rd_count`=16.
- FIFO holds 0xA5, `m_ready`=0:
  - `m_valid`=1 and `m_data`=0xA5 are held for 10 cycles.
  - `fifo_re` is high for 2 reads, then stays low.
  - Raising `m_ready` delivers 0xA5 and the next 2 words in order.
- FIFO empty, `enable`=1 for 20 cycles: `fifo_re`=0 throughout, `m_valid`=0.
- 8 words queued, `enable` dropped after 3 `fifo_re` pulses: exactly 3 words are delivered, and 5 remain in the FIFO.
- `m_ready` toggling 1,0,1,0 over 16 words:
  - No duplicate or dropped word.
  - `occ` ≤ 2 at every edge.
- `rst`=0 for one edge while `occ`=2:
  - Next cycle `m_valid`=0 and `m_data`=0x00.
  - `rd_count` is cleared.
